// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared sequencer state type and default field widths
package sat_pkg;

  localparam int DEF_NUM_CLAUSES      = 8;
  localparam int DEF_NUM_VARS         = 8;
  localparam int DEF_NUM_LVLS         = 8;
  localparam int DEF_WIDTH_LVL        = 16;
  localparam int DEF_WIDTH_BIN_ID     = 15;
  localparam int DEF_WIDTH_VAR_STATES = 19;
  localparam int DEF_WIDTH_LVL_STATES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LISTS,
    ST_START,
    ST_WAIT,
    ST_RDBK,
    ST_FIN
  } seq_state_t;

endpackage

// File: rtl/row_seq.sv
// rtl/row_seq.sv - clause row counter with current and one-cycle delayed one-hot strobes
module row_seq #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [N-1:0]  oh,
  output logic [N-1:0]  oh_d,
  output logic          last
);

  // the phase spans N+1 cycles: rows 0..N-1, then one cycle for the delayed strobe
  always_ff @(posedge clk) begin
    if (rst || !en) cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

  assign oh   = (en && (cnt < CW'(N))) ? (N'(1) << cnt) : '0;
  assign last = en && (cnt == CW'(N));

  always_ff @(posedge clk) begin
    if (rst) oh_d <= '0;
    else     oh_d <= oh;
  end

endmodule

// File: rtl/sat_bin_seq.sv
// rtl/sat_bin_seq.sv - loads one clause bin into the SAT engine, runs it and writes the clauses back
module sat_bin_seq
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES      = DEF_NUM_CLAUSES,
  parameter int NUM_VARS         = DEF_NUM_VARS,
  parameter int NUM_LVLS         = DEF_NUM_LVLS,
  parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
  parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
  parameter int WIDTH_VAR_STATES = DEF_WIDTH_VAR_STATES,
  parameter int WIDTH_LVL_STATES = DEF_WIDTH_LVL_STATES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
  input  logic [WIDTH_LVL-1:0]                   load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
  input  logic                                   wb_en_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   sat_o,
  output logic                                   unsat_o,
  output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_o,
  output logic                                   mem_rd_o,
  output logic                                   mem_wr_o,
  output logic [WIDTH_BIN_ID+2:0]                mem_addr_o,
  output logic [2*NUM_VARS-1:0]                  mem_wdata_o,
  input  logic [2*NUM_VARS-1:0]                  mem_rdata_i,
  output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
  output logic [NUM_CLAUSES-1:0]                 rd_carray_o,
  output logic [2*NUM_VARS-1:0]                  clause_o,
  output logic [NUM_VARS-1:0]                    wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   var_states_o,
  output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
  output logic                                   start_core_o,
  output logic [WIDTH_BIN_ID-1:0]                cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]                   load_lvl_o,
  output logic                                   base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]                   base_lvl_i_o,
  input  logic                                   done_core_i,
  input  logic                                   sat_i,
  input  logic                                   unsat_i,
  input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
  input  logic [2*NUM_VARS-1:0]                  clause_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   var_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i
);

  localparam int AW = WIDTH_BIN_ID + 3;
  localparam int CW = $clog2(NUM_CLAUSES) + 1;

  seq_state_t state, state_n;

  logic [WIDTH_BIN_ID-1:0]              cap_bin;
  logic [WIDTH_LVL-1:0]                 cap_load, cap_base, cap_bkt;
  logic                                 cap_wb, cap_sat, cap_unsat;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] cap_vs, cap_rvs;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] cap_ls, cap_rls;

  logic [CW-1:0]          load_cnt, rdbk_cnt;
  logic [NUM_CLAUSES-1:0] load_oh, load_oh_d, rdbk_oh, rdbk_oh_d;
  logic                   load_last, rdbk_last;
  logic [AW-1:0]          base_addr;
  logic                   fin_load, hold_ph;

  row_seq #(.N(NUM_CLAUSES), .CW(CW)) u_load_seq (
    .clk(clk), .rst(rst), .en(state == ST_LOAD),
    .cnt(load_cnt), .oh(load_oh), .oh_d(load_oh_d), .last(load_last)
  );

  row_seq #(.N(NUM_CLAUSES), .CW(CW)) u_rdbk_seq (
    .clk(clk), .rst(rst), .en(state == ST_RDBK),
    .cnt(rdbk_cnt), .oh(rdbk_oh), .oh_d(rdbk_oh_d), .last(rdbk_last)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start_i) state_n = ST_LOAD;
      ST_LOAD:  if (load_last) state_n = ST_LISTS;
      ST_LISTS: state_n = ST_START;
      ST_START: state_n = ST_WAIT;
      ST_WAIT:  if (done_core_i) state_n = cap_wb ? ST_RDBK : ST_FIN;
      ST_RDBK:  if (rdbk_last) state_n = ST_FIN;
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // results become visible on the FIN cycle itself; skipping WAIT capture when going straight to FIN
  assign fin_load = (state_n == ST_FIN) && (state != ST_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_o     <= 1'b0;
      unsat_o   <= 1'b0;
      bkt_lvl_o <= '0;
    end else if (fin_load) begin
      sat_o     <= (state == ST_WAIT) ? sat_i     : cap_sat;
      unsat_o   <= (state == ST_WAIT) ? unsat_i   : cap_unsat;
      bkt_lvl_o <= (state == ST_WAIT) ? bkt_lvl_i : cap_bkt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start_i) begin
      cap_bin  <= bin_id_i;
      cap_load <= load_lvl_i;
      cap_base <= base_lvl_i;
      cap_wb   <= wb_en_i;
      cap_vs   <= vs_i;
      cap_ls   <= ls_i;
    end
    if (state == ST_WAIT && done_core_i) begin
      cap_sat   <= sat_i;
      cap_unsat <= unsat_i;
      cap_bkt   <= bkt_lvl_i;
      cap_rvs   <= var_states_i;
      cap_rls   <= lvl_states_i;
    end
    if (!rst && fin_load) begin
      vs_o <= (state == ST_WAIT) ? var_states_i : cap_rvs;
      ls_o <= (state == ST_WAIT) ? lvl_states_i : cap_rls;
    end
  end

  assign base_addr = AW'(cap_bin) * AW'(NUM_CLAUSES);

  // write-back addresses trail the read strobe by one row, hence cnt-1
  always_comb begin
    mem_addr_o = '0;
    if (|load_oh)        mem_addr_o = base_addr + AW'(load_cnt);
    else if (|rdbk_oh_d) mem_addr_o = base_addr + AW'(rdbk_cnt) - AW'(1);
  end

  assign mem_rd_o    = |load_oh;
  assign mem_wr_o    = |rdbk_oh_d;
  assign mem_wdata_o = mem_wr_o ? clause_i : '0;
  assign wr_carray_o = load_oh_d;
  assign clause_o    = (|load_oh_d) ? mem_rdata_i : '0;
  assign rd_carray_o = rdbk_oh;

  assign wr_var_states_o = (state == ST_LISTS) ? '1 : '0;
  assign wr_lvl_states_o = (state == ST_LISTS) ? '1 : '0;
  assign var_states_o    = (state == ST_LISTS) ? cap_vs : '0;
  assign lvl_states_o    = (state == ST_LISTS) ? cap_ls : '0;

  assign hold_ph       = (state == ST_START) || (state == ST_WAIT) ||
                         (state == ST_RDBK)  || (state == ST_FIN);
  assign start_core_o  = (state == ST_START);
  assign base_lvl_en_o = (state == ST_START);
  assign cur_bin_num_o = hold_ph ? cap_bin  : '0;
  assign load_lvl_o    = hold_ph ? cap_load : '0;
  assign base_lvl_i_o  = hold_ph ? cap_base : '0;

  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_FIN);

endmodule
